// File: rtl/dma_chan_arbiter.sv
// ============================================================================
// dma_chan_arbiter
//
// Purpose
//   N-channel DMA arbiter. Grants one channel at a time to the shared transfer
//   engine and holds the grant until the engine reports req_done. It then
//   acknowledges the channel and arbitrates again. An optional watchdog aborts
//   a grant that runs too long without req_done.
//
//   Eligibility has three classes. Only the highest non-empty class competes:
//     C0 = req & ~ack                       explicit requests
//     C1 = ch_en & ~t0_done & ~target       t0-direction work pending
//     C2 = ch_en & ~fifo_empty & target     t1-direction data pending
//
// Configuration macro
//   DMA_ARB_RR_EN : when defined, the winner inside a class is chosen round
//                   robin, searching upward from the channel after the last
//                   winner. When undefined, the lowest index wins (legacy
//                   fixed priority).
//
// Parameters
//   NUM_CH       number of channels (2..16)
//   TIMEOUT_CYC  WORK cycles without req_done before abort (0 = no watchdog)
//   TO_W         width of the watchdog counter
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   req          per-channel request level (dropped by requester after ack)
//   ch_en        channel enabled
//   target       per-channel direction: 0 = t0, 1 = t1
//   t0_done      t0-direction transfer of channel complete
//   fifo_empty   channel FIFO empty
//   req_done     engine finished the current grant
//   en           one-hot enable to the granted channel (registered)
//   ack          one-cycle completion pulse for C0 grants (registered)
//   grant_id     index of the last or current granted channel
//   busy         arbiter is not idle
//   timeout_err  one-cycle pulse on watchdog abort
// ============================================================================
module dma_chan_arbiter #(
    parameter  int NUM_CH      = 4,
    parameter  int TIMEOUT_CYC = 0,
    parameter  int TO_W        = 16,
    localparam int CH_W        = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] target,
    input  logic [NUM_CH-1:0] t0_done,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic              req_done,
    output logic [NUM_CH-1:0] en,
    output logic [NUM_CH-1:0] ack,
    output logic [CH_W-1:0]   grant_id,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WORK  = 2'd2
    } state_t;

    localparam bit            WD_ON    = (TIMEOUT_CYC > 0);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
    localparam logic [NUM_CH-1:0] ONE_CH = NUM_CH'(1);

    state_t            cs_reg, cs_next;
    logic [NUM_CH-1:0] en_reg, en_next;
    logic [NUM_CH-1:0] ack_reg, ack_next;
    logic [CH_W-1:0]   grant_reg, grant_next;
    logic              to_reg, to_next;
    logic [TO_W-1:0]   wd_cnt_reg, wd_cnt_next;

    logic [NUM_CH-1:0] c0_vec, c1_vec, c2_vec;
    logic [NUM_CH-1:0] cls_vec;
    logic              any_elig;
    logic [CH_W-1:0]   winner;

    // ------------------------------------------------------------------
    // Per-channel class membership. ack_reg masks C0 for the single IDLE
    // cycle that follows a completion, so a requester that has not yet
    // dropped req is not granted again straight away.
    // ------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < NUM_CH; gi++) begin : g_cls
        assign c0_vec[gi] = req[gi] & ~ack_reg[gi];
        assign c1_vec[gi] = ch_en[gi] & ~t0_done[gi] & ~target[gi];
        assign c2_vec[gi] = ch_en[gi] & ~fifo_empty[gi] & target[gi];
    end

    // Only the highest non-empty class takes part in the selection.
    assign cls_vec  = (|c0_vec) ? c0_vec : ((|c1_vec) ? c1_vec : c2_vec);
    assign any_elig = |cls_vec;

`ifdef DMA_ARB_RR_EN
    logic [CH_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [CH_W-1:0] rr_idx;

    // Walk the search order backwards so the last assignment is the first
    // set bit found from rr_ptr+1 upward with wrap-around.
    always_comb begin
        winner = '0;
        rr_idx = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            rr_idx = CH_W'((int'(rr_ptr_reg) + k) % NUM_CH);
            if (cls_vec[rr_idx]) begin
                winner = rr_idx;
            end
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (cs_reg == IDLE && any_elig) begin
            rr_ptr_next = winner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= CH_W'(NUM_CH - 1);
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end
`else
    // Fixed priority: scanning from the top down leaves the lowest set index.
    always_comb begin
        winner = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (cls_vec[k]) begin
                winner = CH_W'(k);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        cs_next     = cs_reg;
        grant_next  = grant_reg;
        ack_next    = '0;
        to_next     = 1'b0;
        wd_cnt_next = wd_cnt_reg;

        case (cs_reg)
            IDLE: begin
                if (any_elig) begin
                    cs_next    = START;
                    grant_next = winner;
                end
            end
            START: begin
                cs_next     = WORK;
                wd_cnt_next = '0;
            end
            WORK: begin
                if (req_done) begin
                    // A done that coincides with the watchdog limit still
                    // counts as a normal completion.
                    cs_next             = IDLE;
                    ack_next[grant_reg] = req[grant_reg];
                end else if (WD_ON && wd_cnt_reg == TO_LIMIT) begin
                    cs_next = IDLE;
                    to_next = 1'b1;
                end else begin
                    wd_cnt_next = wd_cnt_reg + TO_W'(1);
                end
            end
            default: begin
                cs_next = IDLE;
            end
        endcase

        // grant_reg is already latched when START looks ahead to WORK.
        en_next = (cs_next == WORK) ? (ONE_CH << grant_reg) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_reg     <= IDLE;
            en_reg     <= '0;
            ack_reg    <= '0;
            grant_reg  <= '0;
            to_reg     <= 1'b0;
            wd_cnt_reg <= '0;
        end else begin
            cs_reg     <= cs_next;
            en_reg     <= en_next;
            ack_reg    <= ack_next;
            grant_reg  <= grant_next;
            to_reg     <= to_next;
            wd_cnt_reg <= wd_cnt_next;
        end
    end

    assign en          = en_reg;
    assign ack         = ack_reg;
    assign grant_id    = grant_reg;
    assign busy        = (cs_reg != IDLE);
    assign timeout_err = to_reg;

endmodule

// File: tb/tb_dma_chan_arbiter.sv
// ============================================================================
// tb_dma_chan_arbiter
//
// Bench for dma_chan_arbiter with NUM_CH=4 and an 8-cycle watchdog.
// A transaction-level reference model tracks the arbiter phase, the granted
// channel and cycles spent working, and a compare process checks every DUT
// output against it on each falling edge. Directed scenarios add literal
// expectations at fixed cycle offsets. Honours DMA_ARB_RR_EN if defined.
// ============================================================================
module tb_dma_chan_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;
`ifdef DMA_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] ch_en = '0;
    logic [N-1:0] target = '0;
    logic [N-1:0] t0_done = '0;
    logic [N-1:0] fifo_empty = '1;
    logic         req_done = 1'b0;
    logic [N-1:0] en;
    logic [N-1:0] ack;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout_err;

    always #5 clk = ~clk;

    dma_chan_arbiter #(
        .NUM_CH      (N),
        .TIMEOUT_CYC (TO),
        .TO_W        (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ch_en       (ch_en),
        .target      (target),
        .t0_done     (t0_done),
        .fifo_empty  (fifo_empty),
        .req_done    (req_done),
        .en          (en),
        .ack         (ack),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // phase: 0 idle, 1 grant starting, 2 engine working
    // ------------------------------------------------------------------
    int           m_phase, m_gid, m_rr, m_wcnt;
    logic [N-1:0] m_en, m_ack;
    logic         m_to;

    function automatic int pick(input logic [N-1:0] r, input logic [N-1:0] a,
                                input logic [N-1:0] ce, input logic [N-1:0] tg,
                                input logic [N-1:0] td, input logic [N-1:0] fe,
                                input int rr);
        logic [N-1:0] cls [3];
        int base;
        cls[0] = r & ~a;
        cls[1] = ce & ~td & ~tg;
        cls[2] = ce & ~fe & tg;
        base   = RR_MODE ? rr + 1 : 0;
        for (int c = 0; c < 3; c++) begin
            if (cls[c] != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (cls[c][(base + k) % N]) return (base + k) % N;
                end
            end
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int           w, ph, g, rrn, wc;
        logic [N-1:0] na;
        logic         nt;
        if (rst) begin
            m_phase <= 0;
            m_gid   <= 0;
            m_rr    <= N - 1;
            m_wcnt  <= 0;
            m_en    <= '0;
            m_ack   <= '0;
            m_to    <= 1'b0;
        end else begin
            ph  = m_phase;
            g   = m_gid;
            rrn = m_rr;
            wc  = m_wcnt;
            na  = '0;
            nt  = 1'b0;
            if (ph == 0) begin
                w = pick(req, m_ack, ch_en, target, t0_done, fifo_empty, m_rr);
                if (w >= 0) begin
                    g   = w;
                    rrn = w;
                    ph  = 1;
                end
            end else if (ph == 1) begin
                ph = 2;
                wc = 0;
            end else begin
                if (req_done) begin
                    na[g] = req[g];
                    ph    = 0;
                end else if (TO > 0 && wc == TO - 1) begin
                    nt = 1'b1;
                    ph = 0;
                end else begin
                    wc = wc + 1;
                end
            end
            m_phase <= ph;
            m_gid   <= g;
            m_rr    <= rrn;
            m_wcnt  <= wc;
            m_ack   <= na;
            m_to    <= nt;
            m_en    <= (ph == 2) ? (N'(1) << g) : '0;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("model_en",          32'(en),          32'(m_en));
            check("model_ack",         32'(ack),         32'(m_ack));
            check("model_grant_id",    32'(grant_id),    32'(m_gid));
            check("model_busy",        32'(busy),        32'(m_phase != 0));
            check("model_timeout_err", 32'(timeout_err), 32'(m_to));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int i = 0; i < 12 && idx < 0; i++) begin
            if (en != '0) begin
                for (int b = 0; b < N; b++) if (en[b]) idx = b;
            end else begin
                @(negedge clk);
            end
        end
        if (idx < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL grant_wait: en stayed 0 for 12 cycles, a grant was required");
        end
    endtask

    int got [5];
    int exp_order [5];

    initial begin
`ifdef DMA_ARB_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        // ack masks the just-finished requester for one IDLE cycle
        exp_order = '{0, 1, 0, 1, 0};
`endif
        // Reset state
        @(negedge clk);
        chk_on = 1'b1;
        check("reset_en", 32'(en), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_grant_id", 32'(grant_id), 0);
        tick(1);
        rst = 1'b0;

        // req_done while idle is ignored
        req_done = 1'b1;
        tick(2);
        check("idle_done_busy", 32'(busy), 0);
        check("idle_done_ack", 32'(ack), 0);
        req_done = 1'b0;

        // Basic grant latency and ack masking
        req = 4'b0101;
        tick(1);
        check("lat_start_en", 32'(en), 0);
        check("lat_start_busy", 32'(busy), 1);
        tick(1);
        check("lat_en_ch0", 32'(en), 32'h1);
        check("lat_gid_ch0", 32'(grant_id), 0);
        tick(1);
        req_done = 1'b1;
        tick(1);
        check("done_ack_ch0", 32'(ack), 32'h1);
        check("done_en_off", 32'(en), 0);
        req      = 4'b0100;
        req_done = 1'b0;
        tick(2);
        check("next_en_ch2", 32'(en), 32'h4);
        check("next_gid_ch2", 32'(grant_id), 2);
        req_done = 1'b1;
        tick(1);
        check("done_ack_ch2", 32'(ack), 32'h4);
        req      = '0;
        req_done = 1'b0;
        tick(2);

        // Class order: C1 (ch3) beats C2 (ch0); ch_en drop keeps the grant
        ch_en      = 4'b1111;
        target     = 4'b0001;
        fifo_empty = 4'b1110;
        t0_done    = 4'b0111;
        tick(2);
        check("class_en_ch3", 32'(en), 32'h8);
        check("class_gid_ch3", 32'(grant_id), 3);
        ch_en = 4'b0111;
        tick(2);
        check("chen_drop_holds", 32'(en), 32'h8);
        req_done = 1'b1;
        ch_en    = '0;
        tick(1);
        check("class_no_ack", 32'(ack), 0);
        check("class_en_off", 32'(en), 0);
        req_done   = 1'b0;
        target     = '0;
        fifo_empty = '1;
        t0_done    = '0;
        tick(2);

        // Grant order with all requests held
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_grant(got[g]);
            tick(2);
            req_done = 1'b1;
            tick(1);
            req_done = 1'b0;
            if (g == 4) req = '0;
        end
        for (int g = 0; g < 5; g++) begin
            check($sformatf("order_%0d", g), 32'(got[g]), 32'(exp_order[g]));
        end
        tick(2);

        // Watchdog abort, then a normal regrant
        req = 4'b0001;
        tick(2);
        check("wd_en_rise", 32'(en), 32'h1);
        tick(7);
        check("wd_en_held", 32'(en), 32'h1);
        check("wd_not_yet", 32'(timeout_err), 0);
        tick(1);
        check("wd_timeout_pulse", 32'(timeout_err), 1);
        check("wd_en_off", 32'(en), 0);
        check("wd_no_ack", 32'(ack), 0);
        tick(2);
        check("wd_regrant_en", 32'(en), 32'h1);

        // req_done on the watchdog limit cycle counts as done
        tick(7);
        req_done = 1'b1;
        tick(1);
        check("wdlim_ack", 32'(ack), 32'h1);
        check("wdlim_no_timeout", 32'(timeout_err), 0);
        req      = '0;
        req_done = 1'b0;
        tick(2);

        // Reset in the middle of WORK
        req = 4'b0010;
        tick(3);
        check("midrst_working", 32'(en), 32'h2);
        rst = 1'b1;
        req = '0;
        tick(1);
        check("midrst_en", 32'(en), 0);
        check("midrst_ack", 32'(ack), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_gid", 32'(grant_id), 0);
        check("midrst_timeout", 32'(timeout_err), 0);
        tick(1);
        rst = 1'b0;
        tick(2);
        check("post_rst_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
